// File: rtl/chunked_sub_sequencer_pkg.sv
// Shared types and helpers for the chunked subtract sequencer.
// State encodings and chunk-index width derivation.
package chunked_sub_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_NEG  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Bits needed to index n chunks, never less than one.
    function automatic int cidx_width(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/chunked_sub_sequencer_if.sv
// Requester-side handshake and result bus of the subtract sequencer.
// The master issues start/a/b; the slave returns status and results.
interface chunked_sub_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] mag;

    modport master (
        output start, a, b,
        input  ready, done, diff, borrow, mag
    );

    modport slave (
        input  start, a, b,
        output ready, done, diff, borrow, mag
    );
endinterface

// File: rtl/chunked_sub_sequencer_slice.sv
// Combinational ripple-borrow subtractor of one SLICE-bit chunk.
// Computes d = x - y - bin with borrow-out bout.
module slice_subtractor #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x_i,
    input  logic [SLICE-1:0] y_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] d_o,
    output logic             bout_o
);
    logic br;

    // Ripple the borrow from bit 0 upward.
    always_comb begin
        br  = bin_i;
        d_o = '0;
        for (int i = 0; i < SLICE; i++) begin
            d_o[i] = x_i[i] ^ y_i[i] ^ br;
            br     = (~x_i[i] & y_i[i]) | (~(x_i[i] ^ y_i[i]) & br);
        end
        bout_o = br;
    end
endmodule

// File: rtl/chunked_sub_sequencer.sv
// Multi-cycle WIDTH-bit subtractor reusing one SLICE-bit slice.
// Forms a-b chunk by chunk, then 0-diff when negative for the magnitude.
module chunked_sub_sequencer
    import chunked_sub_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    chunked_sub_sequencer_if.slave  bus
);
    localparam int NCH    = WIDTH / SLICE;
    localparam int CIDX_W = cidx_width(NCH);
    localparam logic [CIDX_W-1:0] LAST = CIDX_W'(NCH - 1);

    state_e            state_q, state_d;
    logic [CIDX_W-1:0] idx_q, idx_d;
    logic              bin_q, bin_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic              borrow_q, borrow_d;

    logic [SLICE-1:0]  sx, sy, sd;
    logic              sbout;

    // Operand mux: a/b chunks while subtracting, 0/diff chunk while negating.
    always_comb begin
        sx = '0;
        sy = diff_q[int'(idx_q)*SLICE +: SLICE];
        if (state_q == S_SUB) begin
            sx = a_q[int'(idx_q)*SLICE +: SLICE];
            sy = b_q[int'(idx_q)*SLICE +: SLICE];
        end
    end

    slice_subtractor #(.SLICE(SLICE)) u_slice (
        .x_i    (sx),
        .y_i    (sy),
        .bin_i  (bin_q),
        .d_o    (sd),
        .bout_o (sbout)
    );

    // Next-state, chunk counter and result update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        mag_d    = mag_q;
        borrow_d = borrow_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = '0;
                    bin_d   = 1'b0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                diff_d[int'(idx_q)*SLICE +: SLICE] = sd;
                bin_d = sbout;
                idx_d = idx_q + CIDX_W'(1);
                if (idx_q == LAST) begin
                    borrow_d = sbout;
                    idx_d    = '0;
                    if (sbout) begin
                        bin_d   = 1'b0;
                        state_d = S_NEG;
                    end else begin
                        mag_d   = diff_d;
                        state_d = S_DONE;
                    end
                end
            end
            S_NEG: begin
                mag_d[int'(idx_q)*SLICE +: SLICE] = sd;
                bin_d = sbout;
                idx_d = idx_q + CIDX_W'(1);
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    bin_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            bin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            mag_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bin_q    <= bin_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            mag_q    <= mag_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.ready  = (state_q == S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.diff   = diff_q;
    assign bus.mag    = mag_q;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_chunked_sub_sequencer.sv
// Directed and random checks for chunked_sub_sequencer (WIDTH=8, SLICE=4).
// Expected values come from hand-computed constants or plain a-b arithmetic.
module tb_chunked_sub_sequencer;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chunked_sub_sequencer_if #(.WIDTH(8)) bus ();

    chunked_sub_sequencer #(.WIDTH(8), .SLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic op_check(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] ed,
                            input logic eb, input logic [7:0] em,
                            input int elat);
        int lat;
        do_op(a, b, lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_diff"}, {24'd0, bus.diff}, {24'd0, ed});
        check({tag, "_borrow"}, {31'd0, bus.borrow}, {31'd0, eb});
        check({tag, "_mag"}, {24'd0, bus.mag}, {24'd0, em});
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] vd [4];
        logic [7:0] ra, rb, rd, rm;
        logic rbw;
        int ndone, k, got, last_acc;

        va = '{8'h35, 8'h80, 8'hFF, 8'h44};
        vb = '{8'h12, 8'h80, 8'h01, 8'h40};
        vd = '{8'h23, 8'h00, 8'hFE, 8'h04};

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_diff", {24'd0, bus.diff}, 32'd0);
        check("rst_mag", {24'd0, bus.mag}, 32'd0);
        check("rst_borrow", {31'd0, bus.borrow}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        op_check("pos", 8'h35, 8'h12, 8'h23, 1'b0, 8'h23, 3);
        op_check("neg", 8'h12, 8'h35, 8'hDD, 1'b1, 8'h23, 5);
        op_check("zmax", 8'h00, 8'hFF, 8'h01, 1'b1, 8'hFF, 5);
        op_check("eq", 8'h80, 8'h80, 8'h00, 1'b0, 8'h00, 3);
        op_check("maxz", 8'hFF, 8'h00, 8'hFF, 1'b0, 8'hFF, 3);

        // start pulsed while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h12;
        bus.b = 8'h35;
        @(posedge clk);
        #1 bus.start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.start = (c == 1);
            bus.a = 8'h01;
            bus.b = 8'h02;
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                check("busy_diff", {24'd0, bus.diff}, 32'hDD);
                check("busy_mag", {24'd0, bus.mag}, 32'h23);
                check("busy_borrow", {31'd0, bus.borrow}, 32'd1);
            end
        end
        bus.start = 1'b0;
        check("busy_ndone", ndone, 1);

        // reset in the second SUB cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h12;
        bus.b = 8'h35;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_diff", {24'd0, bus.diff}, 32'd0);
        check("arst_mag", {24'd0, bus.mag}, 32'd0);
        check("arst_borrow", {31'd0, bus.borrow}, 32'd0);
        check("arst_ready", {31'd0, bus.ready}, 32'd1);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("arst_nodone", ndone, 0);
        check("arst_idle", {31'd0, bus.ready}, 32'd1);

        // start held high: one accept every four cycles
        k = 0;
        got = 0;
        last_acc = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.ready && k < 4) begin
                if (k > 0) check("b2b_gap", c - last_acc, 4);
                last_acc = c;
                bus.start = 1'b1;
                bus.a = va[k];
                bus.b = vb[k];
                k++;
            end else if (bus.ready) begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done && got < 4) begin
                check("b2b_diff", {24'd0, bus.diff}, {24'd0, vd[got]});
                check("b2b_mag", {24'd0, bus.mag}, {24'd0, vd[got]});
                check("b2b_borrow", {31'd0, bus.borrow}, 32'd0);
                got++;
            end
        end
        bus.start = 1'b0;
        check("b2b_count", got, 4);

        // random pairs against plain arithmetic
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rd = ra - rb;
            rbw = (ra < rb);
            rm = rbw ? (rb - ra) : (ra - rb);
            op_check("rnd", ra, rb, rd, rbw, rm, rbw ? 5 : 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
